parking_occupancy_ctrl: RTL
===========================

Name: parking_occupancy_ctrl

Overview:
Parametrised car-park occupancy controller, successor to the fixed 2-bit car counter. It tracks occupancy up to CAPACITY and drives a single entry barrier through a request/open/pass handshake. A slot is reserved for each granted entry, so the car park can never be overbooked. It also flags exit underflow and sits between the gate sensors and the display/indicator logic.

Parameters:
CAPACITY, 3, maximum number of parked cars (>=1)
CNT_W, $clog2(CAPACITY+1), width of count outputs
ALMOST_FULL_MARGIN, 1, Is_almost_full asserts when (CAPACITY - cars_count) <= this value
TIMEOUT_CYCLES, 1000, cycles the barrier stays open without entry_pass before the grant is withdrawn (used only with PARK_TIMEOUT_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset
entry_req  input  1  level request from entry-lane sensor; car waiting at barrier
entry_pass  input  1  one-cycle pulse, car has crossed entry barrier
exit_pass  input  1  one-cycle pulse, car has crossed exit barrier
clr_err  input  1  clears sticky error flags
gate_open  output  1  entry barrier open (registered)
entry_reject  output  1  one-cycle pulse, request refused because no free slot
entry_timeout  output  1  one-cycle pulse, open barrier withdrawn without a pass
cars_count  output  CNT_W  current occupancy
free_slots  output  CNT_W  CAPACITY - cars_count - reserved
Is_empty  output  1  cars_count == 0
Is_full  output  1  cars_count == CAPACITY
Is_almost_full  output  1  see ALMOST_FULL_MARGIN
err_underflow  output  1  sticky; exit_pass seen with nothing to decrement
err_spurious  output  1  sticky; entry_pass seen while gate not open

Behaviour:
- Reset (reset==0 at clk edge): FSM->IDLE; cars_count=0, reserved=0, gate_open=0, entry_reject=0, entry_timeout=0, err_underflow=0, err_spurious=0, timeout counter=0. Flags derived from the count: Is_empty=1, Is_full=0, free_slots=CAPACITY, Is_almost_full=(CAPACITY<=ALMOST_FULL_MARGIN).
- Reset mid-operation: abandons any open grant with no pulse outputs; the count is lost.
- Entry FSM states: IDLE, OPEN, WAIT_CLR.
  - IDLE, entry_req=1, free_slots>0: next cycle gate_open=1, reserved=1, state OPEN.
  - IDLE, entry_req=1, free_slots==0: entry_reject pulses 1 cycle, state WAIT_CLR.
  - OPEN, entry_pass=1: cars_count+1, reserved=0, gate_open=0, state WAIT_CLR.
  - OPEN, timeout expiry (feature only): gate_open=0, reserved=0, entry_timeout pulses, state WAIT_CLR.
  - WAIT_CLR: stays until entry_req==0, then IDLE. Exactly one grant or one reject per request assertion.
- Latency: request to gate_open is 1 cycle; pass to count update is 1 cycle. All outputs are registered or derived from registers.
- Net count update per cycle: inc = (state==OPEN && entry_pass); dec = exit_pass && (cars_count + inc > 0); next = cars_count + inc - dec.
  - Simultaneous entry and exit: count unchanged, no error.
- Underflow: exit_pass with cars_count==0 and no inc gives count held at 0 and err_underflow set.
- Overflow is impossible by construction, because inc requires a reservation. Is_full blocks new grants.
- entry_pass outside OPEN: ignored, err_spurious set.
- Error flags: sticky until clr_err=1 (synchronous clear). Same-cycle set beats clear.
- Widths: all arithmetic in CNT_W+1 bits internally; no wrap-around possible.

Optional Feature:
PARK_TIMEOUT_EN
- Defined: a CNT counter of $clog2(TIMEOUT_CYCLES+1) bits runs in OPEN. When it reaches TIMEOUT_CYCLES with no entry_pass, the grant is withdrawn as above. entry_pass in the expiry cycle wins: counted, no timeout.
- Undefined: no timer; OPEN waits indefinitely for entry_pass; entry_timeout tied 0.

Test Plan:
- Reset, then three grant+pass sequences (CAPACITY=3) -> cars_count=3, Is_full=1, free_slots=0, Is_almost_full=1 after the 2nd car.
- Full park, entry_req held 5 cycles -> exactly one entry_reject pulse, gate_open stays 0, count stays 3.
- Count=2, grant open (free_slots=0), second request after WAIT_CLR -> rejected; then entry_pass -> count=3.
- Count=0, exit_pass -> count 0, err_underflow=1. Then clr_err -> 0. Then entry_pass+exit_pass in the same cycle during OPEN -> count 0, no error.
- PARK_TIMEOUT_EN, TIMEOUT_CYCLES=4: grant with no pass -> entry_timeout after 4 cycles, free_slots restored. Pass on the expiry cycle -> counted, no timeout.
- reset driven low while OPEN with count=2 -> next cycle count=0, gate_open=0, state IDLE.

Source files
------------

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - car-park occupancy counter with reserved-slot entry barrier FSM
// Optional barrier grant timeout enabled by defining PARK_TIMEOUT_EN.
module parking_occupancy_ctrl #(
    parameter int CAPACITY           = 3,
    parameter int CNT_W              = $clog2(CAPACITY + 1),
    parameter int ALMOST_FULL_MARGIN = 1,
    parameter int TIMEOUT_CYCLES     = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             entry_req,
    input  logic             entry_pass,
    input  logic             exit_pass,
    input  logic             clr_err,
    output logic             gate_open,
    output logic             entry_reject,
    output logic             entry_timeout,
    output logic [CNT_W-1:0] cars_count,
    output logic [CNT_W-1:0] free_slots,
    output logic             Is_empty,
    output logic             Is_full,
    output logic             Is_almost_full,
    output logic             err_underflow,
    output logic             err_spurious
);

    typedef enum logic [1:0] {IDLE, OPEN, WAIT_CLR} state_t;

    localparam logic [CNT_W:0] CAP_EXT    = (CNT_W + 1)'(CAPACITY);
    localparam logic [CNT_W:0] MARGIN_EXT = (CNT_W + 1)'(ALMOST_FULL_MARGIN);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic             r_gate_open;
    logic             r_reject;
    logic             r_timeout;
    logic             r_err_uf;
    logic             r_err_sp;

    logic             w_grant;
    logic             w_reject;
    logic             w_expire;
    logic             w_expire_cond;
    logic             w_inc;
    logic             w_dec;
    logic [CNT_W:0]   w_cnt_ext;
    logic [CNT_W:0]   w_free;
    logic [CNT_W:0]   w_room;
    logic [CNT_W:0]   w_next;
    logic             w_unused_next_msb;

    // The open gate doubles as the single reserved slot.
    assign w_cnt_ext = {1'b0, r_count};
    assign w_free    = CAP_EXT - w_cnt_ext - {{CNT_W{1'b0}}, r_gate_open};
    assign w_room    = CAP_EXT - w_cnt_ext;
    assign w_inc     = (r_state == OPEN) && entry_pass;
    assign w_dec     = exit_pass && ((w_cnt_ext + {{CNT_W{1'b0}}, w_inc}) != '0);
    assign w_next    = w_cnt_ext + {{CNT_W{1'b0}}, w_inc} - {{CNT_W{1'b0}}, w_dec};
    assign w_unused_next_msb = w_next[CNT_W];

`ifdef PARK_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMR_W-1:0] r_tmr;

    // Gate stays open for exactly TIMEOUT_CYCLES cycles before withdrawal.
    assign w_expire_cond = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmr <= '0;
        end else if (r_state == OPEN && w_state_next == OPEN) begin
            r_tmr <= r_tmr + 1'b1;
        end else begin
            r_tmr <= '0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_expire_cond = 1'b0;
    assign w_unused_tmo  = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_reject     = 1'b0;
        w_expire     = 1'b0;
        case (r_state)
            IDLE: begin
                if (entry_req) begin
                    if (w_free != '0) begin
                        w_grant      = 1'b1;
                        w_state_next = OPEN;
                    end else begin
                        w_reject     = 1'b1;
                        w_state_next = WAIT_CLR;
                    end
                end
            end
            OPEN: begin
                if (entry_pass) begin
                    w_state_next = WAIT_CLR;
                end else if (w_expire_cond) begin
                    w_expire     = 1'b1;
                    w_state_next = WAIT_CLR;
                end
            end
            WAIT_CLR: begin
                if (!entry_req) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_gate_open <= 1'b0;
            r_reject    <= 1'b0;
            r_timeout   <= 1'b0;
            r_err_uf    <= 1'b0;
            r_err_sp    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_count     <= w_next[CNT_W-1:0];
            r_gate_open <= w_grant || (r_gate_open && w_state_next == OPEN);
            r_reject    <= w_reject;
            r_timeout   <= w_expire;
            if (exit_pass && r_count == '0 && !w_inc) r_err_uf <= 1'b1;
            else if (clr_err)                        r_err_uf <= 1'b0;
            if (entry_pass && r_state != OPEN)       r_err_sp <= 1'b1;
            else if (clr_err)                        r_err_sp <= 1'b0;
        end
    end

    assign gate_open      = r_gate_open;
    assign entry_reject   = r_reject;
    assign entry_timeout  = r_timeout;
    assign cars_count     = r_count;
    assign free_slots     = w_free[CNT_W-1:0];
    assign Is_empty       = (r_count == '0);
    assign Is_full        = (w_cnt_ext == CAP_EXT);
    assign Is_almost_full = (w_room <= MARGIN_EXT);
    assign err_underflow  = r_err_uf;
    assign err_spurious   = r_err_sp;

endmodule
